store_buffer: RTL and testbench

//  Word-granular write buffer between the CPU store path and the DM block.

---
 rtl/store_buffer_pkg.sv | 26 ++
 rtl/sb_fwd_match.sv | 44 ++++
 rtl/store_buffer.sv | 91 +++++++++
 tb/tb_store_buffer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and sizing for the store buffer: entry layout, default depth, word-address helpers.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_PTR_W = 2;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned WORD_W   = 30;

  typedef struct packed {
    logic [WORD_W-1:0] word_addr;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } sb_entry_t;

  // Word address of a byte address (byte offset bits dropped).
  function automatic logic [WORD_W-1:0] word_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:2];
  endfunction

  // Byte address of a word address.
  function automatic logic [ADDR_W-1:0] byte_of(input logic [WORD_W-1:0] word);
    return {word, 2'b00};
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Combinational load-forwarding lookup: scans valid entries oldest to youngest so the
// youngest matching store wins.
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned PTR_W = SB_PTR_W
) (
  input  sb_entry_t         entries [DEPTH],
  input  logic [PTR_W-1:0]  head,
  input  logic [PTR_W:0]    count,
  input  logic [WORD_W-1:0] ld_word,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] idx;
  logic             unused_pc;

  // Later (younger) matches overwrite earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (entries[idx].word_addr == ld_word)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

  // PC field travels with the entry but plays no part in matching.
  always_comb begin
    unused_pc = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      unused_pc = unused_pc ^ (^entries[i].pc);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Word-granular store buffer: queues CPU stores, drains them in order to DM when the port
// is free, and forwards the youngest pending store to matching loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned PTR_W = SB_PTR_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [31:0] st_pc,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        fwd_hit,
  output logic        empty,
  output logic        dm_wr,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rdata
);

  localparam int unsigned CNT_W = PTR_W + 1;

  sb_entry_t          entries [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  logic               full;
  logic               drain;
  logic               accept;
  logic               match_hit;
  logic [DATA_W-1:0]  match_data;
  logic               unused_st_offset;

  // Loads own the DM port; a full buffer still accepts when its head drains this cycle.
  assign full    = (count == CNT_W'(DEPTH));
  assign drain   = (count != '0) & ~ld_valid;
  assign accept  = st_valid & (~full | drain);
  assign stall   = st_valid & ~accept;
  assign empty   = (count == '0);

  assign dm_wr   = drain;
  assign dm_addr = ld_valid ? ld_addr : byte_of(entries[head].word_addr);
  assign dm_wd   = entries[head].data;
  assign dm_pc   = entries[head].pc;

  assign unused_st_offset = ^st_addr[1:0];

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fwd (
    .entries (entries),
    .head    (head),
    .count   (count),
    .ld_word (word_of(ld_addr)),
    .hit     (match_hit),
    .data    (match_data)
  );

  assign fwd_hit = ld_valid & match_hit;
  assign ld_data = fwd_hit ? match_data : dm_rdata;

  // Pointer and occupancy state; reset discards everything pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) tail <= tail + PTR_W'(1);
      if (drain)  head <= head + PTR_W'(1);
      count <= count + CNT_W'(accept) - CNT_W'(drain);
    end
  end

  // Entry payload needs no reset: only slots inside [head, head+count) are ever observed.
  always_ff @(posedge clk) begin
    if (accept) begin
      entries[tail] <= '{word_addr: word_of(st_addr), data: st_data, pc: st_pc};
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: expected DM writes go into a scoreboard queue that a
// negedge monitor checks against every dm_wr; loads, stalls and flags are checked inline.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [31:0] st_pc;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        stall;
  logic [31:0] ld_data;
  logic        fwd_hit;
  logic        empty;
  logic        dm_wr;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [31:0] dm_pc;
  logic [31:0] dm_rdata;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  store_buffer dut (
    .clk      (clk),
    .reset    (reset),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_pc    (st_pc),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .stall    (stall),
    .ld_data  (ld_data),
    .fwd_hit  (fwd_hit),
    .empty    (empty),
    .dm_wr    (dm_wr),
    .dm_addr  (dm_addr),
    .dm_wd    (dm_wd),
    .dm_pc    (dm_pc),
    .dm_rdata (dm_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every DM write must match the oldest outstanding expected store.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (dm_wr !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dm_wr_unexpected: actual dm_wr=%b addr=%h required=no write at %0t",
                 dm_wr, dm_addr, $time);
      end else begin
        e = exp_q.pop_front();
        chk("dm_wr", 32'(dm_wr), 32'd1);
        chk("dm_addr", dm_addr, e.addr);
        chk("dm_wd", dm_wd, e.data);
        chk("dm_pc", dm_pc, e.pc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    st_valid = 1'b0;
    ld_valid = 1'b0;
  endtask

  // One store cycle; ld selects whether a load holds the DM port during it.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc,
                       input logic ld, input logic exp_stall);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_pc    = pc;
    ld_valid = ld;
    @(negedge clk);
    chk("stall", 32'(stall), 32'(exp_stall));
    if (!exp_stall) exp_q.push_back('{a & ~32'h3, d, pc});
    step();
    st_valid = 1'b0;
  endtask

  task automatic load_chk(input logic [31:0] a, input logic exp_hit, input logic [31:0] exp_data);
    st_valid = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = a;
    @(negedge clk);
    chk("fwd_hit", 32'(fwd_hit), 32'(exp_hit));
    chk("ld_data", ld_data, exp_data);
    chk("dm_addr_load", dm_addr, a);
    step();
  endtask

  // Release the port and wait (bounded) for all expected writes, then expect empty.
  task automatic wait_drain();
    idle();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("empty_after_drain", 32'(empty), 32'd1);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_pc    = '0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    dm_rdata = 32'hDEAD_0001;

    // Reset state
    #1;
    st_valid = 1'b1;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_dm_wr", 32'(dm_wr), 32'd0);
    chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
    chk("rst_ld_data", ld_data, 32'hDEAD_0001);
    chk("rst_stall", 32'(stall), 32'd0);
    st_valid = 1'b0;
    step();
    step();
    reset = 1'b0;

    // 1: single store drains the following cycle
    store(32'h10, 32'hAAAA_5555, 32'h3000, 1'b0, 1'b0);
    wait_drain();

    // 2: fill under a held load, fifth store stalls until the load drops
    ld_addr = 32'h100;
    for (int i = 0; i < 4; i++) store(32'(4 * i), 32'h1111_0000 + 32'(i), 32'h3100 + 32'(4 * i), 1'b1, 1'b0);
    @(negedge clk);
    chk("full_not_empty", 32'(empty), 32'd0);
    chk("full_dm_addr_is_ld", dm_addr, 32'h100);
    chk("full_no_dm_wr", 32'(dm_wr), 32'd0);
    step();
    store(32'h10, 32'h1111_0004, 32'h3110, 1'b1, 1'b1);
    store(32'h10, 32'h1111_0004, 32'h3110, 1'b0, 1'b0);
    wait_drain();

    // 3: youngest-match forwarding, byte offset ignored, miss passes dm_rdata
    dm_rdata = 32'h5A5A_0003;
    st_valid = 1'b1; st_addr = 32'h20; st_data = 32'd1; st_pc = 32'h3200;
    ld_valid = 1'b1; ld_addr = 32'h20;
    @(negedge clk);
    chk("same_cycle_store_stall", 32'(stall), 32'd0);
    chk("same_cycle_no_fwd", 32'(fwd_hit), 32'd0);
    chk("same_cycle_ld_data", ld_data, 32'h5A5A_0003);
    exp_q.push_back('{32'h20, 32'd1, 32'h3200});
    step();
    st_data = 32'd2; st_pc = 32'h3204;
    @(negedge clk);
    chk("older_fwd_hit", 32'(fwd_hit), 32'd1);
    chk("older_fwd_data", ld_data, 32'd1);
    exp_q.push_back('{32'h20, 32'd2, 32'h3204});
    step();
    load_chk(32'h20, 1'b1, 32'd2);
    load_chk(32'h23, 1'b1, 32'd2);
    load_chk(32'h24, 1'b0, 32'h5A5A_0003);
    wait_drain();

    // 4: twelve stores interleaved with loads; pointers wrap three times
    for (int i = 0; i < 12; i++) begin
      store(32'h200 + 32'(4 * i), 32'h1000_0000 + 32'(i), 32'h4000 + 32'(4 * i), 1'b0, 1'b0);
      load_chk(32'h200 + 32'(4 * i), 1'b1, 32'h1000_0000 + 32'(i));
    end
    wait_drain();

    // 5: asynchronous reset with stores pending discards them
    ld_addr = 32'h100;
    for (int i = 0; i < 3; i++) store(32'h400 + 32'(4 * i), 32'h2222_0000 + 32'(i), 32'h5000, 1'b1, 1'b0);
    ld_valid = 1'b0;
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("async_rst_empty", 32'(empty), 32'd1);
    chk("async_rst_dm_wr", 32'(dm_wr), 32'd0);
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    @(negedge clk);
    chk("post_rst_empty", 32'(empty), 32'd1);
    chk("post_rst_dm_wr", 32'(dm_wr), 32'd0);
    step();

    // 6: full buffer accepts a store in the same cycle its head drains
    ld_addr = 32'h100;
    for (int i = 0; i < 4; i++) store(32'h300 + 32'(4 * i), 32'h3333_0000 + 32'(i), 32'h6000 + 32'(4 * i), 1'b1, 1'b0);
    store(32'h310, 32'h3333_0004, 32'h6010, 1'b0, 1'b0);
    store(32'h314, 32'h3333_0005, 32'h6014, 1'b1, 1'b1);
    wait_drain();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
